// File: rtl/cpu_param_core.sv
// Multi-cycle accumulator-style CPU core with four general registers.
// Instructions and data share one RAM, which the loader port fills while the
// core is paused in FETCH or stopped in HALT. Input and output use valid/ready
// handshakes, and the flags are {G,Z,C}.
module cpu_param_core #(
    parameter  int DATA_W  = 5,
    parameter  int ADDR_W  = 3,
    localparam int INSTR_W = 8 + DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                load_we,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [INSTR_W-1:0]  load_data,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  ir,
    output logic [2:0]          flags,
    output logic                halted,
    output logic [4*DATA_W-1:0] regs_dbg
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_EXEC     = 3'd1;
    localparam logic [2:0] S_MEM      = 3'd2;
    localparam logic [2:0] S_WAIT_IN  = 3'd3;
    localparam logic [2:0] S_WAIT_OUT = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_ROL  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JG   = 4'hA;
    localparam logic [3:0] OP_IN   = 4'hB;
    localparam logic [3:0] OP_OUT  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    // Rotate left by amt mod DATA_W. Shifting a doubled copy keeps amt=0 well defined.
    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v,
                                               input logic [DATA_W-1:0] amt);
        logic [2*DATA_W-1:0] tmp;
        logic [31:0]         n;
        n   = 32'(amt) % DATA_W;
        tmp = {v, v} << n;
        return tmp[2*DATA_W-1:DATA_W];
    endfunction

    logic [INSTR_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0]  regs_r [4];
    logic [2:0]         state_r, state_n;
    logic [ADDR_W-1:0]  pc_r, pc_n;
    logic [INSTR_W-1:0] ir_r, ir_n;
    logic [2:0]         flags_r, flags_n;
    logic [DATA_W-1:0]  out_data_r, out_data_n;
    logic               out_valid_r, out_valid_n;
    logic               halted_r;

    logic [3:0]         op_s;
    logic [1:0]         rd_idx_s, rs_idx_s;
    logic [DATA_W-1:0]  imm_s, rd_val_s, rs_val_s, rol_s;
    logic [DATA_W:0]    add_s, sub_s;
    logic [ADDR_W-1:0]  pc_inc_s, target_s, ld_addr_s, st_addr_s;
    logic               reg_we_s;
    logic [DATA_W-1:0]  reg_wdata_s;
    logic               st_we_s, loader_en_s, mem_we_s, in_ready_s;
    logic [ADDR_W-1:0]  mem_waddr_s;
    logic [INSTR_W-1:0] mem_wdata_s;

    assign op_s      = ir_r[INSTR_W-1 -: 4];
    assign rd_idx_s  = ir_r[DATA_W+3 -: 2];
    assign rs_idx_s  = ir_r[DATA_W+1 -: 2];
    assign imm_s     = ir_r[DATA_W-1:0];
    assign rd_val_s  = regs_r[rd_idx_s];
    assign rs_val_s  = regs_r[rs_idx_s];
    assign add_s     = {1'b0, rd_val_s} + {1'b0, rs_val_s};
    assign sub_s     = {1'b0, rd_val_s} - {1'b0, rs_val_s};
    assign rol_s     = rotl(rd_val_s, imm_s);
    assign pc_inc_s  = pc_r + ADDR_W'(1'b1);
    assign target_s  = imm_s[ADDR_W-1:0];
    assign ld_addr_s = rs_val_s[ADDR_W-1:0];
    assign st_addr_s = rd_val_s[ADDR_W-1:0];

    // The loader only owns the RAM while the core cannot be executing a ST.
    assign loader_en_s = load_we && (((state_r == S_FETCH) && !run) || (state_r == S_HALT));

    // Next-state, datapath and handshake decode for the multi-cycle sequencer.
    always_comb begin
        state_n     = state_r;
        pc_n        = pc_r;
        ir_n        = ir_r;
        flags_n     = flags_r;
        out_data_n  = out_data_r;
        out_valid_n = out_valid_r;
        reg_we_s    = 1'b0;
        reg_wdata_s = {DATA_W{1'b0}};
        st_we_s     = 1'b0;
        in_ready_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (run) begin
                    ir_n    = mem_r[pc_r];
                    state_n = S_EXEC;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_EXEC: begin
                state_n = S_FETCH;
                pc_n    = pc_inc_s;
                case (op_s)
                    OP_LDI: begin
                        reg_we_s    = 1'b1;
                        reg_wdata_s = imm_s;
                    end
                    OP_LD:  state_n = S_MEM;
                    OP_ST:  st_we_s = 1'b1;
                    OP_ADD: begin
                        reg_we_s    = 1'b1;
                        reg_wdata_s = add_s[DATA_W-1:0];
                        flags_n     = {flags_r[2], add_s[DATA_W-1:0] == {DATA_W{1'b0}}, add_s[DATA_W]};
                    end
                    OP_SUB: begin
                        reg_we_s    = 1'b1;
                        reg_wdata_s = sub_s[DATA_W-1:0];
                        flags_n     = {flags_r[2], sub_s[DATA_W-1:0] == {DATA_W{1'b0}}, sub_s[DATA_W]};
                    end
                    OP_CMP: flags_n = {rd_val_s > rs_val_s, rd_val_s == rs_val_s, flags_r[0]};
                    OP_ROL: begin
                        reg_we_s    = 1'b1;
                        reg_wdata_s = rol_s;
                        flags_n     = {flags_r[2], rol_s == {DATA_W{1'b0}}, 1'b0};
                    end
                    OP_JMP: pc_n = target_s;
                    OP_JZ: begin
                        if (flags_r[1]) begin
                            pc_n = target_s;
                        end else begin
                            pc_n = pc_inc_s;
                        end
                    end
                    OP_JG: begin
                        if (flags_r[2]) begin
                            pc_n = target_s;
                        end else begin
                            pc_n = pc_inc_s;
                        end
                    end
                    OP_IN: begin
                        pc_n    = pc_r;
                        state_n = S_WAIT_IN;
                    end
                    OP_OUT: begin
                        pc_n        = pc_r;
                        out_data_n  = rs_val_s;
                        out_valid_n = 1'b1;
                        state_n     = S_WAIT_OUT;
                    end
                    OP_HALT: begin
                        pc_n    = pc_r;
                        state_n = S_HALT;
                    end
                    default: pc_n = pc_inc_s;
                endcase
            end
            S_MEM: begin
                reg_we_s    = 1'b1;
                reg_wdata_s = mem_r[ld_addr_s][DATA_W-1:0];
                state_n     = S_FETCH;
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    in_ready_s  = 1'b1;
                    reg_we_s    = 1'b1;
                    reg_wdata_s = in_data;
                    pc_n        = pc_inc_s;
                    state_n     = S_FETCH;
                end else begin
                    state_n = S_WAIT_IN;
                end
            end
            S_WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    pc_n        = pc_inc_s;
                    state_n     = S_FETCH;
                end else begin
                    state_n = S_WAIT_OUT;
                end
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    // RAM write port mux: loader and ST are mutually exclusive by state.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {ADDR_W{1'b0}};
        mem_wdata_s = {INSTR_W{1'b0}};
        if (loader_en_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = load_addr;
            mem_wdata_s = load_data;
        end else if (st_we_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = st_addr_s;
            mem_wdata_s = {8'b0, rs_val_s};
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Unified RAM; contents survive reset, writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (reset && mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Architectural state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= S_FETCH;
            pc_r        <= {ADDR_W{1'b0}};
            ir_r        <= {INSTR_W{1'b0}};
            flags_r     <= 3'b000;
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            halted_r    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_r     <= state_n;
            pc_r        <= pc_n;
            ir_r        <= ir_n;
            flags_r     <= flags_n;
            out_data_r  <= out_data_n;
            out_valid_r <= out_valid_n;
            halted_r    <= (state_n == S_HALT);
            if (reg_we_s) begin
                regs_r[rd_idx_s] <= reg_wdata_s;
            end
        end
    end

    // in_ready is the same-cycle accept strobe, so it is decoded rather than registered.
    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign pc        = pc_r;
    assign ir        = ir_r;
    assign flags     = flags_r;
    assign halted    = halted_r;
    assign regs_dbg  = {regs_r[3], regs_r[2], regs_r[1], regs_r[0]};

endmodule

// File: doc/cpu_param_core.md
Name: cpu_param_core

Overview:
Parametrised multi-cycle accumulator-style CPU core. It is the next generation of the team's 5-bit/8-word CPU, generalised in data width and memory depth. It adds an IN/OUT valid/ready handshake, a zero flag, load/subtract/halt instructions, and run/pause control. A unified instruction/data RAM is written by a loader port while the core is paused.

Parameters:
DATA_W, 5, register/ALU width; must be >= ADDR_W.
ADDR_W, 3, RAM address width; depth = 2**ADDR_W.
INSTR_W, 8+DATA_W, instruction/RAM word width; derived, not overridable.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low (0 = reset)
run  in  1  1 = execute; 0 = pause at next FETCH
load_we  in  1  loader write enable; honoured only while in FETCH with run=0, or in HALT
load_addr  in  ADDR_W  loader address
load_data  in  INSTR_W  loader word
in_data  in  DATA_W  input channel data
in_valid  in  1  input data available
in_ready  out  1  one-cycle accept strobe for in_data
out_data  out  DATA_W  output channel data
out_valid  out  1  out_data valid; held until out_ready
out_ready  in  1  consumer accepts
pc  out  ADDR_W  program counter
ir  out  INSTR_W  instruction register
flags  out  3  {G,Z,C}
halted  out  1  core in HALT state
regs_dbg  out  4*DATA_W  {R3,R2,R1,R0}

Behaviour:
- Instruction format {op[3:0], rd[1:0], rs[1:0], imm[DATA_W-1:0]}. Four registers R0..R3. Jump target = imm[ADDR_W-1:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd=imm.
  - 2 LD: rd=mem[rs][DATA_W-1:0].
  - 3 ST: mem[rd]={8'b0,rs}.
  - 4 ADD: rd=rd+rs, C=carry.
  - 5 SUB: rd=rd-rs, C=borrow.
  - 6 CMP: Z=(rd==rs), G=(rd>rs) unsigned; no register write.
  - 7 ROL: rd rotated left by imm mod DATA_W.
  - 8 JMP.
  - 9 JZ: jump if Z.
  - A JG: jump if G.
  - B IN: rd=in_data.
  - C OUT: out_data=rs.
  - D HALT.
  - E, F: NOP.
- Flag updates: ADD, SUB and ROL update Z=(result==0). ROL sets C=0. Other instructions leave flags unchanged.
- Register and memory address arithmetic: ST/LD use rd/rs value [ADDR_W-1:0]; upper bits are ignored.
- States:
  - FETCH: if run, ir<=mem[pc]; go to EXEC. Otherwise stay.
  - EXEC: execute; pc<=pc+1 (mod 2**ADDR_W) or the jump target; go to FETCH. Exceptions: LD goes to MEM, IN goes to WAIT_IN, OUT goes to WAIT_OUT, HALT goes to HALT.
  - MEM: rd<=mem[addr]; go to FETCH.
  - WAIT_IN: when in_valid, rd<=in_data, in_ready=1 for this cycle, pc+1; go to FETCH.
  - WAIT_OUT: out_valid=1; on out_ready, drop out_valid, pc+1; go to FETCH.
  - HALT: stay until reset. halted=1.
- Latency: 2 cycles per ALU/jump/ST instruction, 3 for LD. IN/OUT take >=2 cycles plus the stall.
- The RAM read is combinational; the RAM write occurs on the clock edge in EXEC (ST) or from the loader.
- A ST and a loader write never coincide, because the loader is gated by state.
- The pc update from a jump takes priority over increment. pc wraps 7->0 at the default ADDR_W.
- Deasserting run mid-instruction: the current instruction completes, then the core pauses in FETCH.
- Reset (reset=0 at a clock edge), any state, mid-handshake included:
  - state=FETCH; pc=0; ir=0; R0..R3=0; flags=0.
  - out_data=0; out_valid=0; in_ready=0; halted=0.
  - RAM contents are retained.

Test Plan:
- Load LDI R0,21 (0001_00_00_10101), LDI R1,3, ADD R0,R1 at 0..2, then run=1 -> after 6 cycles R0=24 (11000), C=0, Z=0, pc=3.
- LDI R0,31; LDI R1,1; ADD R0,R1 -> R0=0, C=1, Z=1. Then JZ 6 -> pc=6.
- LDI R2,7; LDI R3,9; ST [R2],R3; LD R1,[R2] -> mem[7]=9 and R1=9. LD takes 3 cycles.
- IN R0 with in_valid held low for 5 cycles, then in_data=10101 valid -> pc frozen while stalled; one in_ready pulse; R0=21. OUT R0 with out_ready low for 3 cycles -> out_valid held with out_data=21 and pc frozen until out_ready.
- ROL R0,2 with R0=10101 -> R0=10110. ROL by 7 (mod 5 = 2) gives the same result. Instruction at address 7 followed by wrap -> next fetch from 0.
- HALT -> halted=1, pc frozen, loader writes accepted. reset=0 asserted mid WAIT_OUT -> out_valid=0, pc=0, registers 0, RAM unchanged.
